// File: rtl/clock_disp_scan.sv
// Six-digit multiplexed 7-segment scanner: snapshots BCD time once per frame, drives
// active-low anodes/segments. Optional colon blink on dp when BLINK_DP_EN is defined.
module clock_disp_scan #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [3:0] hour_h,
  input  logic [3:0] hour_l,
  input  logic [3:0] min_h,
  input  logic [3:0] min_l,
  input  logic [3:0] sec_h,
  input  logic [3:0] sec_l,
  input  logic       sec_tick,
  input  logic       blank_lz,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PresLast = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [23:0]   snap_q, snap_d;
  logic          run_q;
  logic [5:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          presc_wrap;
  logic          frame_start;
  logic          blank;
  logic [3:0]    digit;
  logic [5:0]    an_sel;
  logic          dp_slot;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    case (v)
      4'd0:    bcd_to_seg = 7'h40;
      4'd1:    bcd_to_seg = 7'h79;
      4'd2:    bcd_to_seg = 7'h24;
      4'd3:    bcd_to_seg = 7'h30;
      4'd4:    bcd_to_seg = 7'h19;
      4'd5:    bcd_to_seg = 7'h12;
      4'd6:    bcd_to_seg = 7'h02;
      4'd7:    bcd_to_seg = 7'h78;
      4'd8:    bcd_to_seg = 7'h00;
      4'd9:    bcd_to_seg = 7'h10;
      default: bcd_to_seg = 7'h3F;
    endcase
  endfunction

`ifdef BLINK_DP_EN
  logic blink_q, blink_d;

  assign blink_d = blink_q ^ sec_tick;
  assign dp_slot = ((idx_q == 3'd2) || (idx_q == 3'd4)) ? ~blink_q : 1'b1;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      blink_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
    end
  end
`else
  logic unused_sec_tick;

  assign unused_sec_tick = sec_tick;
  assign dp_slot         = 1'b1;
`endif

  always_comb begin
    presc_wrap  = (presc_q == PresLast);
    presc_d     = presc_wrap ? '0 : presc_q + 1'b1;
    idx_d       = idx_q;
    if (presc_wrap) begin
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end

    frame_start = (presc_q == '0) && (idx_q == 3'd0);
    snap_d      = frame_start ? {hour_h, hour_l, min_h, min_l, sec_h, sec_l} : snap_q;

    // Decode from snap_d so the first slot of a frame already shows the fresh snapshot.
    digit  = 4'd0;
    an_sel = 6'b111111;
    case (idx_q)
      3'd0: begin digit = snap_d[3:0];   an_sel = 6'b111110; end
      3'd1: begin digit = snap_d[7:4];   an_sel = 6'b111101; end
      3'd2: begin digit = snap_d[11:8];  an_sel = 6'b111011; end
      3'd3: begin digit = snap_d[15:12]; an_sel = 6'b110111; end
      3'd4: begin digit = snap_d[19:16]; an_sel = 6'b101111; end
      3'd5: begin digit = snap_d[23:20]; an_sel = 6'b011111; end
      default: ;
    endcase

    blank = (idx_q == 3'd5) && blank_lz && (snap_d[23:20] == 4'd0);

    an_d  = 6'b111111;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    // run_q keeps the first edge after reset dark while the snapshot is taken.
    if (run_q && !blank) begin
      an_d  = an_sel;
      seg_d = bcd_to_seg(digit);
      dp_d  = dp_slot;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      presc_q <= '0;
      idx_q   <= 3'd0;
      snap_q  <= '0;
      run_q   <= 1'b0;
      an_q    <= 6'b111111;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      run_q   <= 1'b1;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_clock_disp_scan.sv
// Directed bench for clock_disp_scan with SCAN_DIV=4; colon-blink checks follow BLINK_DP_EN.
module tb_clock_disp_scan;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic [3:0] hour_h = 4'd0, hour_l = 4'd0, min_h = 4'd0, min_l = 4'd0;
  logic [3:0] sec_h = 4'd0, sec_l = 4'd0;
  logic       sec_tick = 1'b0;
  logic       blank_lz = 1'b0;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int failures = 0;

  logic [5:0] an_tab [6] = '{6'b111110, 6'b111101, 6'b111011, 6'b110111, 6'b101111, 6'b011111};

  clock_disp_scan #(.SCAN_DIV(4)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .hour_h   (hour_h),
    .hour_l   (hour_l),
    .min_h    (min_h),
    .min_l    (min_l),
    .sec_h    (sec_h),
    .sec_l    (sec_l),
    .sec_tick (sec_tick),
    .blank_lz (blank_lz),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_digits(input logic [3:0] hh, hl, mh, ml, sh, sl);
    hour_h = hh; hour_l = hl; min_h = mh; min_l = ml; sec_h = sh; sec_l = sl;
  endtask

  // After this returns, the next tick() is the first non-reset edge (edge 1).
  task automatic apply_reset();
    clr_n = 1'b0;
    repeat (3) tick();
    clr_n = 1'b1;
  endtask

  task automatic test_reset();
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    clr_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (an !== 6'b111111 || seg !== 7'h7F || dp !== 1'b1) begin
      failures++;
      $display("FAIL reset_state an=%b seg=%h dp=%b want 111111/7f/1", an, seg, dp);
    end
    clr_n = 1'b1;
    tick();
    checks++;
    if (an !== 6'b111111) begin
      failures++;
      $display("FAIL first_edge_dark an=%b want 111111", an);
    end
    tick();
    checks++;
    if (an !== 6'b111110 || seg !== 7'h02 || dp !== 1'b1) begin
      failures++;
      $display("FAIL second_edge_slot0 an=%b seg=%h dp=%b want 111110/02/1", an, seg, dp);
    end
  endtask

  task automatic test_scan();
    logic [6:0] es [6];
    int k;
    es = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    blank_lz = 1'b0;
    apply_reset();
    for (int e = 1; e <= 48; e++) begin
      tick();
      if (e >= 2) begin
        k = ((e - 1) / 4) % 6;
        checks++;
        if (an !== an_tab[k] || seg !== es[k] || dp !== 1'b1) begin
          failures++;
          $display("FAIL scan e=%0d an=%b seg=%h dp=%b want %b/%h/1", e, an, seg, dp,
                   an_tab[k], es[k]);
        end
      end
    end
  endtask

  task automatic test_snapshot();
    logic [6:0] old_s [6];
    logic [6:0] new_s [6];
    int k;
    old_s = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    new_s = '{7'h10, 7'h12, 7'h10, 7'h12, 7'h30, 7'h24};
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    apply_reset();
    for (int e = 1; e <= 72; e++) begin
      tick();
      if (e == 38) set_digits(4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9);
      if (e >= 39) begin
        k = ((e - 1) / 4) % 6;
        checks++;
        if (e <= 48) begin
          if (an !== an_tab[k] || seg !== old_s[k]) begin
            failures++;
            $display("FAIL snap_hold e=%0d an=%b seg=%h want %b/%h", e, an, seg, an_tab[k],
                     old_s[k]);
          end
        end else begin
          if (an !== an_tab[k] || seg !== new_s[k]) begin
            failures++;
            $display("FAIL snap_new e=%0d an=%b seg=%h want %b/%h", e, an, seg, an_tab[k],
                     new_s[k]);
          end
        end
      end
    end
  endtask

  task automatic test_blank();
    set_digits(4'd0, 4'd9, 4'd3, 4'd4, 4'd5, 4'd6);
    blank_lz = 1'b1;
    apply_reset();
    repeat (18) tick();
    checks++;
    if (an !== 6'b101111 || seg !== 7'h10) begin
      failures++;
      $display("FAIL blank_hour_l an=%b seg=%h want 101111/10", an, seg);
    end
    repeat (4) tick();
    checks++;
    if (an !== 6'b111111 || seg !== 7'h7F || dp !== 1'b1) begin
      failures++;
      $display("FAIL blank_on an=%b seg=%h dp=%b want 111111/7f/1", an, seg, dp);
    end
    blank_lz = 1'b0;
    tick();
    checks++;
    if (an !== 6'b011111 || seg !== 7'h40) begin
      failures++;
      $display("FAIL blank_off an=%b seg=%h want 011111/40", an, seg);
    end
  endtask

  task automatic test_dash();
    logic [6:0] es [6];
    int k;
    es = '{7'h3F, 7'h12, 7'h19, 7'h3F, 7'h24, 7'h79};
    set_digits(4'd1, 4'd2, 4'hF, 4'd4, 4'd5, 4'hB);
    blank_lz = 1'b0;
    apply_reset();
    for (int e = 1; e <= 24; e++) begin
      tick();
      if (e % 4 == 3) begin
        k = (e - 1) / 4;
        checks++;
        if (an !== an_tab[k] || seg !== es[k]) begin
          failures++;
          $display("FAIL dash e=%0d an=%b seg=%h want %b/%h", e, an, seg, an_tab[k], es[k]);
        end
      end
    end
  endtask

  task automatic test_midreset();
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    apply_reset();
    repeat (14) tick();
    checks++;
    if (an !== 6'b110111 || seg !== 7'h30) begin
      failures++;
      $display("FAIL mid_pre an=%b seg=%h want 110111/30", an, seg);
    end
    clr_n = 1'b0;
    tick();
    checks++;
    if (an !== 6'b111111 || seg !== 7'h7F || dp !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset an=%b seg=%h dp=%b want 111111/7f/1", an, seg, dp);
    end
    clr_n = 1'b1;
    set_digits(4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd8);
    tick();
    checks++;
    if (an !== 6'b111111) begin
      failures++;
      $display("FAIL mid_edge1 an=%b want 111111", an);
    end
    tick();
    checks++;
    if (an !== 6'b111110 || seg !== 7'h00) begin
      failures++;
      $display("FAIL mid_edge2 an=%b seg=%h want 111110/00", an, seg);
    end
  endtask

  task automatic test_blink();
    int k;
    logic exp_dp;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    apply_reset();
`ifdef BLINK_DP_EN
    // single pulse: blink=1, colon dots lit in slots 2 and 4
    sec_tick = 1'b1; tick(); sec_tick = 1'b0;
    for (int e = 2; e <= 24; e++) begin
      tick();
      k = ((e - 1) / 4) % 6;
      exp_dp = (k == 2 || k == 4) ? 1'b0 : 1'b1;
      checks++;
      if (dp !== exp_dp) begin
        failures++;
        $display("FAIL blink_on e=%0d dp=%b want %b", e, dp, exp_dp);
      end
    end
    // two consecutive pulses toggle twice: blink stays 1
    sec_tick = 1'b1; tick(); tick(); sec_tick = 1'b0;
    for (int e = 27; e <= 48; e++) begin
      tick();
      k = ((e - 1) / 4) % 6;
      exp_dp = (k == 2 || k == 4) ? 1'b0 : 1'b1;
      checks++;
      if (dp !== exp_dp) begin
        failures++;
        $display("FAIL blink_double e=%0d dp=%b want %b", e, dp, exp_dp);
      end
    end
    // one more pulse: blink=0, dots dark everywhere
    sec_tick = 1'b1; tick(); sec_tick = 1'b0;
    for (int e = 50; e <= 72; e++) begin
      tick();
      checks++;
      if (dp !== 1'b1) begin
        failures++;
        $display("FAIL blink_off e=%0d dp=%b want 1", e, dp);
      end
    end
`else
    for (int e = 1; e <= 48; e++) begin
      sec_tick = (e % 5 == 1) ? 1'b1 : 1'b0;
      tick();
      checks++;
      if (dp !== 1'b1) begin
        failures++;
        $display("FAIL dp_const e=%0d dp=%b want 1", e, dp);
      end
    end
    sec_tick = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_scan();
    test_snapshot();
    test_blank();
    test_dash();
    test_midreset();
    test_blink();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
